// File: rtl/apb_master_arb.sv
// Round-robin APB master shared by NUM_REQ requesters; SETUP one cycle after an IDLE grant, rsp_valid one cycle after completion.
// Requests wait (req_valid held) until their one-cycle req_ready; the slave stalls ACCESS with pready=0 up to TIMEOUT cycles.
module apb_master_arb #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                      pclk,
    input  logic                      presetn,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic                      psel,
    output logic                      penable,
    output logic                      pwrite,
    output logic [ADDR_W-1:0]         paddr,
    output logic [DATA_W-1:0]         pwdata,
    input  logic [DATA_W-1:0]         prdata,
    input  logic                      pready,
    input  logic                      pslverr
);
    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, win_q;
    logic [CNT_W-1:0]   cnt_q;

    logic               grant_any;
    logic [PTR_W-1:0]   grant_idx, cand;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;
    logic               sel_write;
    logic               timed_out, done, take;

    // Walk downward so the candidate closest to the pointer is the last (winning) assignment.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = PTR_W'((int'(ptr_q) + k) % NUM_REQ);
            if (req_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_write = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == PTR_W'(i)) begin
                sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = req_wdata[i*DATA_W +: DATA_W];
                sel_write = req_write[i];
            end
        end
    end

    always_comb begin
        timed_out = (TIMEOUT > 0) && !pready && (cnt_q == CNT_LAST);
        done      = (state_q == ACCESS) && (pready || timed_out);
        take      = ((state_q == IDLE) || done) && grant_any;
        state_d   = state_q;
        psel      = 1'b0;
        penable   = 1'b0;
        req_ready = '0;
        case (state_q)
            IDLE: begin
                if (grant_any) state_d = SETUP;
            end
            SETUP: begin
                psel      = 1'b1;
                req_ready = NUM_REQ'(1) << win_q;
                state_d   = ACCESS;
            end
            ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
                if (done) state_d = grant_any ? SETUP : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (take) begin
                win_q <= grant_idx;
                ptr_q <= (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            end
            if (state_q == SETUP)
                cnt_q <= '0;
            else if (state_q == ACCESS && !pready)
                cnt_q <= cnt_q + 1'b1;
        end
    end

    // Bus fields only change at a grant, so they stay stable across SETUP/ACCESS and hold in IDLE.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            paddr     <= '0;
            pwdata    <= '0;
            pwrite    <= 1'b0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (take) begin
                paddr  <= sel_addr;
                pwdata <= sel_wdata;
                pwrite <= sel_write;
            end
            rsp_valid <= done ? (NUM_REQ'(1) << win_q) : '0;
            rsp_rdata <= (done && pready && !pwrite) ? prdata : '0;
            rsp_err   <= done && (pready ? pslverr : 1'b1);
        end
    end
endmodule

// File: tb/tb_apb_master_arb.sv
// Random requesters and slave against a transaction-level round-robin/APB model.
module tb_apb_master_arb;
    localparam int NR = 4;
    localparam int AW = 12;
    localparam int DW = 32;
    localparam int TO = 16;

    logic              pclk = 1'b0;
    logic              presetn;
    logic [NR-1:0]     req_valid, req_write;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_wdata;
    logic [NR-1:0]     req_ready, rsp_valid;
    logic [DW-1:0]     rsp_rdata;
    logic              rsp_err;
    logic              psel, penable, pwrite;
    logic [AW-1:0]     paddr;
    logic [DW-1:0]     pwdata;
    logic [DW-1:0]     prdata;
    logic              pready, pslverr;

    apb_master_arb #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .pclk(pclk), .presetn(presetn),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 pclk = ~pclk;

    int n_tests = 0;
    int n_fail  = 0;
    int req_rate;
    bit hang;

    // Model state: what the bus must show this cycle, expressed as pending events.
    int          ptr;
    bit          setup_due, in_acc, rsp_due;
    int          a_win, r_win, wait_cnt;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_wdata, r_data;
    bit          a_write, r_err;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [NR-1:0] v, input int p);
        for (int k = 0; k < NR; k++)
            if (v[(p + k) % NR]) return (p + k) % NR;
        return -1;
    endfunction

    task automatic arbitrate(output bit got);
        int w;
        w   = rr_pick(req_valid, ptr);
        got = (w >= 0);
        if (got) begin
            a_win   = w;
            a_addr  = req_addr[w*AW +: AW];
            a_write = req_write[w];
            a_wdata = req_wdata[w*DW +: DW];
            ptr     = (w + 1) % NR;
        end
    endtask

    task automatic new_req(input int i);
        req_valid[i]         = 1'b1;
        req_write[i]         = 1'($urandom_range(0, 1));
        req_addr[i*AW +: AW] = AW'($urandom);
        req_wdata[i*DW +: DW] = $urandom;
    endtask

    task automatic drive_inputs(input logic [NR-1:0] acc);
        for (int i = 0; i < NR; i++) begin
            if (req_valid[i] && acc[i]) begin
                if ($urandom_range(0, 1) == 1) new_req(i);
                else req_valid[i] = 1'b0;
            end else if (!req_valid[i] && $urandom_range(0, 99) < req_rate) begin
                new_req(i);
            end
        end
        pready  = hang ? 1'b0 : ($urandom_range(0, 2) != 0);
        prdata  = $urandom;
        pslverr = ($urandom_range(0, 5) == 0);
    endtask

    task automatic step();
        logic [NR-1:0] acc;
        bit nxt_setup, nxt_acc;
        @(negedge pclk);
        check_eq("rsp_valid", rsp_valid, rsp_due ? (64'd1 << r_win) : 64'd0);
        if (rsp_due) begin
            check_eq("rsp_rdata", rsp_rdata, r_data);
            check_eq("rsp_err", rsp_err, r_err);
        end
        check_eq("req_ready", req_ready, setup_due ? (64'd1 << a_win) : 64'd0);
        nxt_setup = 1'b0;
        nxt_acc   = in_acc;
        rsp_due   = 1'b0;
        if (setup_due || in_acc) begin
            check_eq(setup_due ? "psel_setup" : "psel_access", {psel, penable}, {1'b1, ~setup_due});
            check_eq("paddr", paddr, a_addr);
            check_eq("pwrite", pwrite, a_write);
            check_eq("pwdata", pwdata, a_wdata);
        end
        if (setup_due) begin
            nxt_acc  = 1'b1;
            wait_cnt = 0;
        end else if (in_acc) begin
            if (pready || (TO > 0 && wait_cnt == TO - 1)) begin
                rsp_due = 1'b1;
                r_win   = a_win;
                r_data  = (pready && !a_write) ? prdata : '0;
                r_err   = pready ? pslverr : 1'b1;
                nxt_acc = 1'b0;
                arbitrate(nxt_setup);
            end else begin
                wait_cnt++;
            end
        end else begin
            check_eq("psel_idle", {psel, penable}, 2'b00);
            arbitrate(nxt_setup);
        end
        setup_due = nxt_setup;
        in_acc    = nxt_acc;
        acc       = req_ready;
        @(posedge pclk);
        #1;
        drive_inputs(acc);
    endtask

    initial begin
        bit found;
        presetn   = 1'b0;
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        prdata    = '0;
        pready    = 1'b0;
        pslverr   = 1'b0;
        hang      = 1'b0;
        req_rate  = 10;
        ptr = 0; setup_due = 0; in_acc = 0; rsp_due = 0; wait_cnt = 0;
        a_win = 0; r_win = 0; a_addr = '0; a_wdata = '0; a_write = 0; r_data = '0; r_err = 0;

        #3;
        check_eq("rst_psel", {psel, penable, pwrite}, 3'b000);
        check_eq("rst_req_ready", req_ready, 0);
        check_eq("rst_rsp_valid", rsp_valid, 0);
        check_eq("rst_rsp_rdata", rsp_rdata, 0);
        check_eq("rst_rsp_err", rsp_err, 0);
        check_eq("rst_paddr", paddr, 0);
        check_eq("rst_pwdata", pwdata, 0);
        @(posedge pclk);
        #3 presetn = 1'b1;

        repeat (1500) step();
        req_rate = 100;
        repeat (800) step();
        hang = 1'b1;
        req_rate = 30;
        repeat (300) step();
        hang = 1'b0;
        req_rate = 20;

        found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            step();
            if (in_acc && !setup_due) found = 1'b1;
        end
        check_eq("reach_access", found, 1'b1);
        #2 presetn = 1'b0;
        #1;
        check_eq("arst_psel", {psel, penable}, 2'b00);
        check_eq("arst_req_ready", req_ready, 0);
        check_eq("arst_rsp_valid", rsp_valid, 0);
        req_valid = '0;
        ptr = 0; setup_due = 0; in_acc = 0; rsp_due = 0;
        repeat (2) @(posedge pclk);
        #3;
        presetn = 1'b1;
        new_req(2);
        new_req(0);
        repeat (500) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
